// File: rtl/me_shift_sched.sv
// me_shift_sched: reference-pixel shift-chain scheduler for motion estimation.
// Optional macro ME_SHIFT_STALL_CNT_EN adds the stall_cnt_o request-stall counter.
module me_shift_sched #(
    parameter int SW_W        = 48,
    parameter int SW_H        = 48,
    parameter int BLK         = 16,
    parameter int LINE_STRIDE = 64,
    parameter int ADDR_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              hold_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_gnt_i,
    input  logic              rd_vld_i,
    output logic              shift_en_o,
    output logic              flush_o,
    output logic              cand_valid_o,
    output logic [7:0]        cand_x_o,
    output logic [7:0]        cand_y_o,
    output logic              busy_o,
    output logic              done_o
`ifdef ME_SHIFT_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, ROW, ROW_END, DONE} state_e;

    localparam logic [7:0] W8     = 8'(SW_W);
    localparam logic [7:0] LAST_X = 8'(SW_W - 1);
    localparam logic [7:0] BLK_M1 = 8'(BLK - 1);
    localparam logic [7:0] Y_MAX  = 8'(SW_H - BLK);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [7:0]        y_q, y_d;
    logic [7:0]        req_x_q, req_x_d;
    logic [7:0]        ret_x_q, ret_x_d;
    logic              cand_valid_q, cand_valid_d;
    logic [7:0]        cand_x_q, cand_x_d;
    logic [7:0]        cand_y_q, cand_y_d;
    logic              req;
    logic              grant;
    logic              shift;

    assign req   = (state_q == ROW) && (req_x_q < W8) && !hold_i;
    assign grant = req && rd_gnt_i;
    assign shift = (state_q == ROW) && rd_vld_i;

    assign rd_req_o     = req;
    assign rd_addr_o    = req ? row_addr_q + ADDR_W'(req_x_q) : '0;
    assign shift_en_o   = shift;
    assign flush_o      = (state_q == ROW_END);
    assign done_o       = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign cand_valid_o = cand_valid_q;
    assign cand_x_o     = cand_x_q;
    assign cand_y_o     = cand_y_q;

    // Next state: request/return column counters, row advance, candidate tag.
    always_comb begin
        state_d      = state_q;
        row_addr_d   = row_addr_q;
        y_d          = y_q;
        req_x_d      = req_x_q;
        ret_x_d      = ret_x_q;
        cand_valid_d = 1'b0;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    row_addr_d = base_i;
                    y_d        = '0;
                    req_x_d    = '0;
                    ret_x_d    = '0;
                    state_d    = ROW;
                end
            end
            ROW: begin
                if (grant) begin
                    req_x_d = req_x_q + 8'd1;
                end
                if (shift) begin
                    ret_x_d = ret_x_q + 8'd1;
                    if (ret_x_q >= BLK_M1) begin
                        cand_valid_d = 1'b1;
                        cand_x_d     = ret_x_q - BLK_M1;
                        cand_y_d     = y_q;
                    end
                    if (ret_x_q == LAST_X) begin
                        state_d = ROW_END;
                    end
                end
            end
            ROW_END: begin
                y_d        = y_q + 8'd1;
                req_x_d    = '0;
                ret_x_d    = '0;
                row_addr_d = row_addr_q + ADDR_W'(LINE_STRIDE);
                state_d    = ((y_q + 8'd1) > Y_MAX) ? DONE : ROW;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            row_addr_q   <= '0;
            y_q          <= '0;
            req_x_q      <= '0;
            ret_x_q      <= '0;
            cand_valid_q <= 1'b0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            row_addr_q   <= row_addr_d;
            y_q          <= y_d;
            req_x_q      <= req_x_d;
            ret_x_q      <= ret_x_d;
            cand_valid_q <= cand_valid_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
        end
    end

`ifdef ME_SHIFT_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of requests left waiting for a grant.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start_i) begin
            stall_d = '0;
        end else if (req && !rd_gnt_i && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_me_shift_sched.sv
// tb_me_shift_sched: randomized self-checking bench for me_shift_sched.
// Instance 0 is an 18x17 window, instance 1 a 16x16 window.
module tb_me_shift_sched;

    logic        clk;
    logic        rst;
    logic        start [2];
    logic [15:0] base [2];
    logic        hold [2];
    logic        gnt [2];
    logic        vld [2];
    logic        rd_req [2];
    logic [15:0] rd_addr [2];
    logic        shift [2];
    logic        flush [2];
    logic        cand_v [2];
    logic [7:0]  cand_x [2];
    logic [7:0]  cand_y [2];
    logic        busy [2];
    logic        done [2];
`ifdef ME_SHIFT_STALL_CNT_EN
    logic [15:0] stall [2];
`endif

    int n_chk;
    int n_pass;

    me_shift_sched #(
        .SW_W(18), .SW_H(17), .BLK(16), .LINE_STRIDE(64), .ADDR_W(16)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .base_i(base[0]),
        .hold_i(hold[0]), .rd_req_o(rd_req[0]), .rd_addr_o(rd_addr[0]),
        .rd_gnt_i(gnt[0]), .rd_vld_i(vld[0]), .shift_en_o(shift[0]),
        .flush_o(flush[0]), .cand_valid_o(cand_v[0]), .cand_x_o(cand_x[0]),
        .cand_y_o(cand_y[0]), .busy_o(busy[0]), .done_o(done[0])
`ifdef ME_SHIFT_STALL_CNT_EN
        , .stall_cnt_o(stall[0])
`endif
    );

    me_shift_sched #(
        .SW_W(16), .SW_H(16), .BLK(16), .LINE_STRIDE(64), .ADDR_W(16)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .base_i(base[1]),
        .hold_i(hold[1]), .rd_req_o(rd_req[1]), .rd_addr_o(rd_addr[1]),
        .rd_gnt_i(gnt[1]), .rd_vld_i(vld[1]), .shift_en_o(shift[1]),
        .flush_o(flush[1]), .cand_valid_o(cand_v[1]), .cand_x_o(cand_x[1]),
        .cand_y_o(cand_y[1]), .busy_o(busy[1]), .done_o(done[1])
`ifdef ME_SHIFT_STALL_CNT_EN
        , .stall_cnt_o(stall[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_quiet(input int k);
        chk("q_req", 32'(rd_req[k]), 0);
        chk("q_addr", 32'(rd_addr[k]), 0);
        chk("q_shift", 32'(shift[k]), 0);
        chk("q_flush", 32'(flush[k]), 0);
        chk("q_cand_v", 32'(cand_v[k]), 0);
        chk("q_cand_x", 32'(cand_x[k]), 0);
        chk("q_cand_y", 32'(cand_y[k]), 0);
        chk("q_busy", 32'(busy[k]), 0);
        chk("q_done", 32'(done[k]), 0);
    endtask

    // mode 0: always granted; 1: random grant/hold plus busy starts;
    // 2: first ten request cycles left ungranted.
    task automatic run_search(input int k, input logic [15:0] b,
                              input int mode);
        int w, h, rows, nreq, nflush, ndone, nshift, stalls, stall_left;
        int ex, ey;
        bit done_seen;
        bit [3:0] pipe;
        logic [15:0] ea;
        logic [15:0] aq[$];
        int cxq[$];
        int cyq[$];
        w = (k == 0) ? 18 : 16;
        h = (k == 0) ? 17 : 16;
        rows = h - 16 + 1;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < w; x++) aq.push_back(b + 16'(y * 64 + x));
            for (int x = 0; x <= w - 16; x++) begin
                cxq.push_back(x);
                cyq.push_back(y);
            end
        end
        nreq = 0; nflush = 0; ndone = 0; nshift = 0; stalls = 0;
        done_seen = 0; pipe = '0;
        stall_left = (mode == 2) ? 10 : 0;
        @(negedge clk);
        start[k] = 1; base[k] = b; gnt[k] = 0; hold[k] = 0; vld[k] = 0;
        #1 chk("idle_busy", 32'(busy[k]), 0);
        @(negedge clk);
        for (int step = 0; step < 3000 && !done_seen; step++) begin
            start[k] = (mode == 1) && (step == 7 || step == 40);
            base[k] = start[k] ? 16'hABCD : b;
            if (mode == 1) gnt[k] = 1'($urandom_range(0, 1));
            else gnt[k] = (stall_left > 0) ? 1'b0 : 1'b1;
            hold[k] = (mode == 1) && ($urandom_range(0, 7) == 0);
            vld[k] = pipe[0];
            #1;
            if (step == 0) begin
                chk("busy", 32'(busy[k]), 1);
`ifdef ME_SHIFT_STALL_CNT_EN
                chk("stall_clr", 32'(stall[k]), 0);
`endif
            end
            if (hold[k]) chk("hold_req", 32'(rd_req[k]), 0);
            chk("shift", 32'(shift[k]), 32'(vld[k]));
            pipe = pipe >> 1;
            if (rd_req[k] && gnt[k]) begin
                nreq++;
                pipe[1] = 1'b1;
                if (aq.size() == 0) begin
                    chk("extra_req", 1, 0);
                end else begin
                    ea = aq.pop_front();
                    chk("addr", 32'(rd_addr[k]), 32'(ea));
                end
            end
            if (rd_req[k] && !gnt[k]) begin
                stalls++;
                if (stall_left > 0) stall_left--;
            end
            if (shift[k]) nshift++;
            if (flush[k]) begin
                chk("row_shifts", nshift, w);
                nshift = 0;
                nflush++;
            end
            if (cand_v[k]) begin
                if (cxq.size() == 0) begin
                    chk("extra_cand", 1, 0);
                end else begin
                    ex = cxq.pop_front();
                    ey = cyq.pop_front();
                    chk("cand_x", 32'(cand_x[k]), ex);
                    chk("cand_y", 32'(cand_y[k]), ey);
                end
            end
            if (done[k]) begin
                ndone++;
                done_seen = 1;
                chk("done_busy", 32'(busy[k]), 1);
            end
            @(negedge clk);
        end
        start[k] = 0; gnt[k] = 0; hold[k] = 0; vld[k] = pipe[0];
        #1;
        chk("done_seen", 32'(done_seen), 1);
        chk("busy_drop", 32'(busy[k]), 0);
        chk("done_pulse", 32'(done[k]), 0);
        chk("n_done", ndone, 1);
        chk("n_req", nreq, w * rows);
        chk("n_flush", nflush, rows);
        chk("addr_left", aq.size(), 0);
        chk("cand_left", cxq.size(), 0);
`ifdef ME_SHIFT_STALL_CNT_EN
        chk("stall", 32'(stall[k]), stalls);
`endif
    endtask

    task automatic reset_mid_row();
        bit [3:0] pipe;
        int n;
        pipe = '0;
        n = 0;
        @(negedge clk);
        start[0] = 1; base[0] = 16'h0100; gnt[0] = 0; vld[0] = 0;
        @(negedge clk);
        start[0] = 0;
        for (int i = 0; i < 50 && n < 5; i++) begin
            gnt[0] = 1;
            vld[0] = pipe[0];
            #1;
            pipe = pipe >> 1;
            if (rd_req[0] && gnt[0]) begin
                n++;
                pipe[1] = 1'b1;
            end
            @(negedge clk);
        end
        chk("rst_grants", n, 5);
        rst = 1; gnt[0] = 0; vld[0] = pipe[0];
        @(negedge clk);
        rst = 0; vld[0] = 1;
        #1 chk_quiet(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vld[0] = 1;
            #1;
            chk("late_shift", 32'(shift[0]), 0);
            chk("late_busy", 32'(busy[0]), 0);
        end
        @(negedge clk);
        vld[0] = 0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            start[k] = 0; base[k] = '0; hold[k] = 0; gnt[k] = 0; vld[k] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk_quiet(0);
        chk_quiet(1);
`ifdef ME_SHIFT_STALL_CNT_EN
        chk("rst_stall", 32'(stall[0]), 0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vld[0] = 1; gnt[0] = 1;
            #1;
            chk("idle_vld_shift", 32'(shift[0]), 0);
            chk("idle_req", 32'(rd_req[0]), 0);
            chk("idle_cand", 32'(cand_v[0]), 0);
        end
        @(negedge clk);
        vld[0] = 0; gnt[0] = 0;
        run_search(0, 16'h0100, 0);
        run_search(0, 16'h0100, 1);
        reset_mid_row();
        run_search(0, 16'h0100, 0);
        run_search(1, 16'hFFF8, 0);
        run_search(0, 16'h0200, 2);
        run_search(0, 16'h0300, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/me_shift_sched.md
Name: me_shift_sched

Overview:
- Scheduler for the motion-estimation reference-pixel shift chain.
- Fetches search-window columns from reference memory over a req/gnt/vld handshake and drives the chain's shift enable, one shift per returned word.
- Pulses a flush between candidate rows and tags each fully populated window position as a candidate (x, y) for the SAD stage.
- Sits between the reference-memory port and the FIFO shift stages.

Parameters:
- SW_W, 48, search-window width in pixel columns (words per row); must be >= BLK.
- SW_H, 48, search-window height in pixel rows; must be >= BLK.
- BLK, 16, block size; shift-chain depth in columns.
- LINE_STRIDE, 64, address increment between search rows.
- ADDR_W, 16, memory address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  one-cycle pulse; begin a search; ignored while busy_o=1.
- base_i  in  ADDR_W  window base address; latched on accepted start.
- hold_i  in  1  suppresses new requests only; in-flight returns still shift.
- rd_req_o  out  1  memory read request.
- rd_addr_o  out  ADDR_W  read address; valid while rd_req_o=1.
- rd_gnt_i  in  1  request accepted this cycle.
- rd_vld_i  in  1  in-order read data return; one per granted request.
- shift_en_o  out  1  advance shift chain (combinational: rd_vld_i & state==ROW).
- flush_o  out  1  one-cycle pulse; clear shift chain.
- cand_valid_o  out  1  window holds a complete candidate.
- cand_x_o  out  8  candidate column offset.
- cand_y_o  out  8  candidate row offset.
- busy_o  out  1  search in progress.
- done_o  out  1  one-cycle pulse at search end.

Behaviour:
- Reset: state=IDLE; all counters 0; every output 0 (rd_addr_o=0, cand_x_o/cand_y_o=0).
- Reset mid-search: immediate return to IDLE. Returns arriving afterwards are ignored.
- FSM states are IDLE, ROW, ROW_END, DONE.
- IDLE:
  - start_i latches base_i and sets y=0, req_x=0, ret_x=0.
  - Next state is ROW. busy_o=1 from the following cycle until the cycle after done_o.
- ROW, request side:
  - rd_req_o=1 while req_x<SW_W and !hold_i.
  - rd_addr_o = base + y*LINE_STRIDE + req_x, modulo 2^ADDR_W.
  - A request is granted when rd_req_o & rd_gnt_i; req_x increments on each grant.
  - hold_i deasserts rd_req_o in the same cycle.
- ROW, return side:
  - On rd_vld_i, shift_en_o=1 in the same cycle and ret_x increments.
  - cand_valid_o is registered, high the cycle after a shift where ret_x (pre-increment) >= BLK-1.
  - cand_x_o = ret_x-(BLK-1); cand_y_o = y.
- ROW exit: on the return with ret_x==SW_W-1, go to ROW_END.
- ROW_END, one cycle:
  - flush_o=1.
  - y increments; req_x and ret_x clear.
  - If the new y > SW_H-BLK, go to DONE; otherwise go to ROW.
- DONE, one cycle: done_o=1, then IDLE.
- Counts:
  - Candidates per row = SW_W-BLK+1; rows = SW_H-BLK+1.
  - Defaults give 33×33 = 1089 candidates.
- Rows do not overlap: no requests for row y+1 are issued until all SW_W returns of row y are received.
- Simultaneous events:
  - A grant and a return in the same cycle both count.
  - rd_vld_i outside ROW is ignored (no shift).
  - start_i during busy is ignored.
  - rd_gnt_i without rd_req_o is ignored.

Optional Feature:
- Macro: ME_SHIFT_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o[15:0], counting cycles with rd_req_o=1 & rd_gnt_i=0.
  - Saturates at 0xFFFF, clears on accepted start_i and on reset, and holds its value after done_o.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Run with SW_W=18, SW_H=17, BLK=16, LINE_STRIDE=64, base_i=0x0100, rd_gnt_i=1 and rd_vld_i delayed 2 cycles:
  - 36 requests issued.
  - Row 0 addresses are 0x0100..0x0111; row 1 addresses are 0x0140..0x0151.
  - 6 cand_valid_o pulses: (0,0), (1,0), (2,0), (0,1), (1,1), (2,1).
  - 2 flush_o pulses, then done_o once; busy_o then drops.
- Random rd_gnt_i (50%) and hold_i pulses:
  - Candidate sequence is identical to the previous run.
  - No rd_req_o while hold_i=1.
  - Shift count per row is exactly SW_W.
- Assert rst_i mid-row 0 (after 5 grants) while returns are still in flight:
  - Next cycle all outputs are 0 and state is IDLE.
  - Late rd_vld_i produces no shift_en_o.
  - A new start_i then runs the full search normally.
- start_i pulses while busy_o=1, and rd_vld_i injected in IDLE: no effect on counters, addresses or outputs.
- SW_W=BLK=16, SW_H=16: exactly 1 candidate (0,0), 1 flush_o, done_o; address wrap with base_i=0xFFF8 wraps rd_addr_o to 0x0000..0x0007.
- With ME_SHIFT_STALL_CNT_EN defined, rd_gnt_i held low for 10 request cycles: stall_cnt_o=10; a new start_i clears it to 0.
